inst_axi_line_fetch: RTL

- Instruction-side AXI4 read master that refills one I-cache line per request, using a single INCR burst of LINE_WORDS beats.
- Sits between the I-cache miss logic (request/response, valid/ready) and the AXI read-address and read-data channels.
- Generalises the single-beat fetch interface: parametrised line size and AXI ID, bounded-depth request buffering, RRESP/RLAST error detection, and a flush that discards an in-flight refill without breaking the AXI protocol.

---
 rtl/inst_fetch_pkg.sv | 21 ++
 rtl/inst_axi_line_fetch_if.sv | 31 +++
 rtl/fetch_req_fifo.sv | 49 ++++
 rtl/inst_axi_line_fetch.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/inst_fetch_pkg.sv
// Shared constants, state type and helpers for the instruction line-fetch AXI master.
package inst_fetch_pkg;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [2:0] SIZE_4B    = 3'b010;
  localparam logic [1:0] RESP_OKAY  = 2'b00;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_RESP,
    S_DRAIN
  } state_t;

  // Address mask that clears the byte offset within a line of 32-bit words.
  function automatic logic [63:0] line_mask(input int unsigned line_words);
    return ~((64'(line_words) * 64'd4) - 64'd1);
  endfunction

endpackage

// File: rtl/inst_axi_line_fetch_if.sv
// AXI4 read-address and read-data channels used by the line-fetch master.
interface inst_axi_line_fetch_if #(
  parameter int ADDR_W = 32
) ();
  logic [3:0]        ARID;
  logic [ADDR_W-1:0] ARADDR;
  logic [7:0]        ARLEN;
  logic [2:0]        ARSIZE;
  logic [1:0]        ARBURST;
  logic [1:0]        ARLOCK;
  logic [3:0]        ARCACHE;
  logic [2:0]        ARPROT;
  logic              ARVALID;
  logic              ARREADY;
  logic [3:0]        RID;
  logic [31:0]       RDATA;
  logic [1:0]        RRESP;
  logic              RLAST;
  logic              RVALID;
  logic              RREADY;

  modport master (
    output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARLOCK, ARCACHE, ARPROT, ARVALID, RREADY,
    input  ARREADY, RID, RDATA, RRESP, RLAST, RVALID
  );

  modport slave (
    input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARLOCK, ARCACHE, ARPROT, ARVALID, RREADY,
    output ARREADY, RID, RDATA, RRESP, RLAST, RVALID
  );
endinterface

// File: rtl/fetch_req_fifo.sv
// Small synchronous FIFO (1 or 2 entries) holding line-aligned miss addresses.
module fetch_req_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             clear,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);
  localparam logic LAST_PTR = 1'(DEPTH - 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             rd_q;
  logic             wr_q;
  logic [1:0]       cnt_q;
  logic             do_push;
  logic             do_pop;

  // A push into a full FIFO is legal when the head leaves in the same cycle.
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;
  assign full    = (cnt_q == 2'(DEPTH));
  assign empty   = (cnt_q == 2'd0);
  assign head    = mem_q[rd_q];

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (do_push && !clear) mem_q[wr_q] <= din;
  end

  // Pointer and occupancy tracking; clear discards everything queued.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      rd_q  <= 1'b0;
      wr_q  <= 1'b0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= (wr_q == LAST_PTR) ? 1'b0 : wr_q + 1'b1;
      if (do_pop)  rd_q <= (rd_q == LAST_PTR) ? 1'b0 : rd_q + 1'b1;
      cnt_q <= cnt_q + 2'(do_push) - 2'(do_pop);
    end
  end
endmodule

// File: rtl/inst_axi_line_fetch.sv
// I-cache line refill master: one AXI4 INCR burst of LINE_WORDS beats per miss request.
module inst_axi_line_fetch
  import inst_fetch_pkg::*;
#(
  parameter int unsigned LINE_WORDS = 8,
  parameter logic [3:0]  AXI_ID     = 4'h0,
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned REQ_DEPTH  = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req_valid,
  input  logic [ADDR_W-1:0]        req_addr,
  output logic                     req_ready,
  input  logic                     flush,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [ADDR_W-1:0]        resp_addr,
  output logic [32*LINE_WORDS-1:0] resp_line,
  output logic                     resp_err,
  output logic                     busy,
  inst_axi_line_fetch_if.master    axi
);
  localparam int unsigned       CNT_W     = $clog2(LINE_WORDS) + 1;
  localparam logic [63:0]       MASK64    = line_mask(LINE_WORDS);
  localparam logic [ADDR_W-1:0] LINE_MASK = MASK64[ADDR_W-1:0];
  localparam logic [CNT_W-1:0]  LAST_CNT  = CNT_W'(LINE_WORDS - 1);

  state_t                  state_q, state_d;
  logic [ADDR_W-1:0]       araddr_q, araddr_d;
  logic                    arvalid_q, arvalid_d;
  logic                    rready_q, rready_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [32*LINE_WORDS-1:0] line_q, line_d;
  logic                    err_q, err_d;
  logic                    pend_q, pend_d;

  logic              fifo_full, fifo_empty, pop, push;
  logic [ADDR_W-1:0] fifo_head;
  logic              beat, last, beat_err;

  fetch_req_fifo #(
    .DEPTH (REQ_DEPTH),
    .WIDTH (ADDR_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .clear (flush),
    .din   (req_addr & LINE_MASK),
    .head  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign req_ready = (!fifo_full || pop) && !flush;
  assign push      = req_valid && req_ready;

  assign beat     = axi.RVALID && rready_q;
  assign last     = (cnt_q == LAST_CNT);
  assign beat_err = (axi.RRESP != RESP_OKAY) || (axi.RID != AXI_ID) || (axi.RLAST != last);

  assign axi.ARID    = AXI_ID;
  assign axi.ARADDR  = araddr_q;
  assign axi.ARLEN   = 8'(LINE_WORDS - 1);
  assign axi.ARSIZE  = SIZE_4B;
  assign axi.ARBURST = BURST_INCR;
  assign axi.ARLOCK  = '0;
  assign axi.ARCACHE = '0;
  assign axi.ARPROT  = '0;
  assign axi.ARVALID = arvalid_q;
  assign axi.RREADY  = rready_q;

  // ARADDR doubles as the response address: it is frozen from AR issue until the line is handed over.
  assign resp_valid = (state_q == S_RESP);
  assign resp_addr  = araddr_q;
  assign resp_line  = line_q;
  assign resp_err   = err_q;
  assign busy       = (state_q != S_IDLE) || !fifo_empty;

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      araddr_q  <= '0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      cnt_q     <= '0;
      line_q    <= '0;
      err_q     <= 1'b0;
      pend_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      araddr_q  <= araddr_d;
      arvalid_q <= arvalid_d;
      rready_q  <= rready_d;
      cnt_q     <= cnt_d;
      line_q    <= line_d;
      err_q     <= err_d;
      pend_q    <= pend_d;
    end
  end

  // Next-state, AXI handshakes, beat capture and flush handling.
  always_comb begin
    state_d   = state_q;
    araddr_d  = araddr_q;
    arvalid_d = arvalid_q;
    rready_d  = rready_q;
    cnt_d     = cnt_q;
    line_d    = line_q;
    err_d     = err_q;
    pend_d    = pend_q;
    pop       = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        err_d  = 1'b0;
        pend_d = 1'b0;
        if (!fifo_empty && !flush) begin
          pop       = 1'b1;
          araddr_d  = fifo_head;
          arvalid_d = 1'b1;
          state_d   = S_ADDR;
        end
      end
      S_ADDR: begin
        // A flush here cannot withdraw ARVALID, so remember it until the address is accepted.
        if (flush) pend_d = 1'b1;
        if (axi.ARREADY) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          cnt_d     = '0;
          state_d   = (flush || pend_q) ? S_DRAIN : S_DATA;
        end
      end
      S_DATA: begin
        if (flush) state_d = S_DRAIN;
        if (beat) begin
          for (int unsigned i = 0; i < LINE_WORDS; i++) begin
            if (cnt_q == CNT_W'(i)) line_d[32*i +: 32] = axi.RDATA;
          end
          cnt_d = cnt_q + 1'b1;
          if (beat_err) err_d = 1'b1;
          if (last) begin
            rready_d = 1'b0;
            state_d  = flush ? S_IDLE : S_RESP;
          end
        end
      end
      S_RESP: begin
        if (flush) begin
          err_d   = 1'b0;
          state_d = S_IDLE;
        end else if (resp_ready) begin
          err_d = 1'b0;
          if (!fifo_empty) begin
            pop       = 1'b1;
            araddr_d  = fifo_head;
            arvalid_d = 1'b1;
            state_d   = S_ADDR;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_DRAIN: begin
        if (beat) begin
          cnt_d = cnt_q + 1'b1;
          if (last) begin
            rready_d = 1'b0;
            state_d  = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end
endmodule
